// File: rtl/register_file_pkg.sv
// =============================================================================
//  Module      : register_file_pkg
//  Description : Shared widths and sentinel encodings for the register file,
//                dispatcher and reorder buffer.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

package register_file_pkg;
   localparam int REG_WIDTH    = 5;
   localparam int EX_REG_WIDTH = 6;
   localparam int RoB_WIDTH    = 8;
   localparam int EX_RoB_WIDTH = 9;
   localparam int REG_NUM      = 32;

   localparam logic [EX_REG_WIDTH-1:0] NON_REG = 6'b100000;
   localparam logic [EX_RoB_WIDTH-1:0] NON_DEP = 9'b100000000;

   // x0 and any index with the "no register" bit set are never real operands
   function automatic logic is_arch_reg(input logic [EX_REG_WIDTH-1:0] r);
      return (r[EX_REG_WIDTH-1] == 1'b0) && (r[REG_WIDTH-1:0] != '0);
   endfunction
endpackage

`default_nettype wire

// File: rtl/register_file_if.sv
// =============================================================================
//  Module      : register_file_if
//  Description : Commit, dispatch-read and rename signals around the register file.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

interface register_file_if;
   import register_file_pkg::*;

   logic                    Sys_rdy;
   logic                    RoBRF_pre_judge;
   logic                    RoBRF_en;
   logic [RoB_WIDTH-1:0]    RoBRF_RoB_index;
   logic [EX_REG_WIDTH-1:0] RoBRF_rd;
   logic [31:0]             RoBRF_value;
   logic [EX_REG_WIDTH-1:0] DPRF_rs1;
   logic [EX_REG_WIDTH-1:0] DPRF_rs2;
   logic                    DPRF_en;
   logic [EX_REG_WIDTH-1:0] DPRF_rd;
   logic [RoB_WIDTH-1:0]    DPRF_RoB_index;
   logic [31:0]             RFDP_Vj;
   logic [31:0]             RFDP_Vk;
   logic [EX_RoB_WIDTH-1:0] RFDP_Qj;
   logic [EX_RoB_WIDTH-1:0] RFDP_Qk;

   modport master (
      output Sys_rdy, RoBRF_pre_judge, RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value,
      output DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
      input  RFDP_Vj, RFDP_Vk, RFDP_Qj, RFDP_Qk
   );

   modport slave (
      input  Sys_rdy, RoBRF_pre_judge, RoBRF_en, RoBRF_RoB_index, RoBRF_rd, RoBRF_value,
      input  DPRF_rs1, DPRF_rs2, DPRF_en, DPRF_rd, DPRF_RoB_index,
      output RFDP_Vj, RFDP_Vk, RFDP_Qj, RFDP_Qk
   );
endinterface

`default_nettype wire

// File: rtl/register_file_rf_read_port.sv
// =============================================================================
//  Module      : rf_read_port
//  Description : Combinational operand read with same-cycle commit bypass.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

module rf_read_port
   import register_file_pkg::*;
(
   input  wire logic [EX_REG_WIDTH-1:0]              rs,
   input  wire logic [REG_NUM-1:0][31:0]             values,
   input  wire logic [REG_NUM-1:0][EX_RoB_WIDTH-1:0] tags,
   input  wire logic                                 commit_en,
   input  wire logic [EX_REG_WIDTH-1:0]              commit_rd,
   input  wire logic [RoB_WIDTH-1:0]                 commit_rob,
   input  wire logic [31:0]                          commit_value,
   output logic      [31:0]                          v,
   output logic      [EX_RoB_WIDTH-1:0]              q
);
   logic [REG_WIDTH-1:0] w_idx;

   assign w_idx = rs[REG_WIDTH-1:0];

   always_comb begin
      v = '0;
      q = NON_DEP;
      if (is_arch_reg(rs)) begin
         // Only the commit that owns the current rename may forward its value
         if (commit_en && (commit_rd == rs) && (tags[w_idx] == {1'b0, commit_rob})) begin
            v = commit_value;
            q = NON_DEP;
         end else begin
            v = values[w_idx];
            q = tags[w_idx];
         end
      end
   end
endmodule

`default_nettype wire

// File: rtl/register_file.sv
// =============================================================================
//  Module      : register_file
//  Description : Architectural register file with rename tags, commit bypass and
//                misprediction flush. Optional trace: define REGFILE_TRACE_EN.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

module register_file
   import register_file_pkg::*;
(
   input  wire logic        Sys_clk,
   input  wire logic        Sys_rst_n,
   register_file_if.slave   bus
);
   logic [REG_NUM-1:0][31:0]             r_values;
   logic [REG_NUM-1:0][EX_RoB_WIDTH-1:0] r_tags;

   logic                    w_commit_ok;
   logic                    w_rename_ok;
   logic [REG_WIDTH-1:0]    w_c_idx;
   logic [REG_WIDTH-1:0]    w_d_idx;
   logic [EX_RoB_WIDTH-1:0] w_commit_tag;
   logic [EX_RoB_WIDTH-1:0] w_rename_tag;
   logic [31:0]             w_vj;
   logic [31:0]             w_vk;
   logic [EX_RoB_WIDTH-1:0] w_qj;
   logic [EX_RoB_WIDTH-1:0] w_qk;

   assign w_commit_ok  = bus.RoBRF_en && is_arch_reg(bus.RoBRF_rd);
   assign w_rename_ok  = bus.DPRF_en && bus.RoBRF_pre_judge && is_arch_reg(bus.DPRF_rd);
   assign w_c_idx      = bus.RoBRF_rd[REG_WIDTH-1:0];
   assign w_d_idx      = bus.DPRF_rd[REG_WIDTH-1:0];
   assign w_commit_tag = {1'b0, bus.RoBRF_RoB_index};
   assign w_rename_tag = {1'b0, bus.DPRF_RoB_index};

   always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
      if (!Sys_rst_n) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_values[i] <= '0;
            r_tags[i]   <= NON_DEP;
         end
      end else if (bus.Sys_rdy) begin
         if (w_commit_ok) begin
            r_values[w_c_idx] <= bus.RoBRF_value;
         end
         if (!bus.RoBRF_pre_judge) begin
            for (int i = 0; i < REG_NUM; i++) begin
               r_tags[i] <= NON_DEP;
            end
         end else begin
            // A same-cycle rename of the committing register keeps the newer tag
            if (w_commit_ok && (r_tags[w_c_idx] == w_commit_tag) &&
                !(w_rename_ok && (w_d_idx == w_c_idx))) begin
               r_tags[w_c_idx] <= NON_DEP;
            end
            if (w_rename_ok) begin
               r_tags[w_d_idx] <= w_rename_tag;
            end
         end
      end
   end

   rf_read_port u_read_rs1 (
      .rs           (bus.DPRF_rs1),
      .values       (r_values),
      .tags         (r_tags),
      .commit_en    (bus.RoBRF_en),
      .commit_rd    (bus.RoBRF_rd),
      .commit_rob   (bus.RoBRF_RoB_index),
      .commit_value (bus.RoBRF_value),
      .v            (w_vj),
      .q            (w_qj)
   );

   rf_read_port u_read_rs2 (
      .rs           (bus.DPRF_rs2),
      .values       (r_values),
      .tags         (r_tags),
      .commit_en    (bus.RoBRF_en),
      .commit_rd    (bus.RoBRF_rd),
      .commit_rob   (bus.RoBRF_RoB_index),
      .commit_value (bus.RoBRF_value),
      .v            (w_vk),
      .q            (w_qk)
   );

   assign bus.RFDP_Vj = w_vj;
   assign bus.RFDP_Vk = w_vk;
   assign bus.RFDP_Qj = w_qj;
   assign bus.RFDP_Qk = w_qk;

`ifdef REGFILE_TRACE_EN
   always @(posedge Sys_clk) begin
      if (Sys_rst_n && bus.Sys_rdy) begin
         if (w_commit_ok) begin
            $display("rf x%0d <= %h (rob %0d)", w_c_idx, bus.RoBRF_value, bus.RoBRF_RoB_index);
         end
         if (w_rename_ok) begin
            assert (w_rename_tag[EX_RoB_WIDTH-1] == 1'b0)
               else $error("rename tag has no-dependency bit set");
         end
      end
   end
`endif
endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// =============================================================================
//  Module      : tb_register_file
//  Description : Directed vector table plus hand-written reset sequence.
//  Revision    : 1.0
// =============================================================================
`default_nettype none

module tb_register_file;
   import register_file_pkg::*;

   typedef struct {
      logic        rdy;
      logic        pj;
      logic        c_en;
      logic [5:0]  c_rd;
      logic [7:0]  c_rob;
      logic [31:0] c_val;
      logic        d_en;
      logic [5:0]  d_rd;
      logic [7:0]  d_rob;
      logic [5:0]  rs1;
      logic [5:0]  rs2;
      logic [31:0] ej_v;
      logic [8:0]  ej_q;
      logic [31:0] ek_v;
      logic [8:0]  ek_q;
   } vec_t;

   localparam logic [5:0] NR = 6'b100000;
   localparam logic [8:0] ND = 9'b100000000;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   vec_t vecs[$];

   register_file_if rf_bus ();

   register_file dut (
      .Sys_clk   (clk),
      .Sys_rst_n (rst_n),
      .bus       (rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(
      input logic rdy, input logic pj,
      input logic c_en, input logic [5:0] c_rd, input logic [7:0] c_rob, input logic [31:0] c_val,
      input logic d_en, input logic [5:0] d_rd, input logic [7:0] d_rob,
      input logic [5:0] rs1, input logic [5:0] rs2,
      input logic [31:0] ej_v, input logic [8:0] ej_q,
      input logic [31:0] ek_v, input logic [8:0] ek_q);
      vec_t t;
      t.rdy = rdy; t.pj = pj;
      t.c_en = c_en; t.c_rd = c_rd; t.c_rob = c_rob; t.c_val = c_val;
      t.d_en = d_en; t.d_rd = d_rd; t.d_rob = d_rob;
      t.rs1 = rs1; t.rs2 = rs2;
      t.ej_v = ej_v; t.ej_q = ej_q; t.ek_v = ek_v; t.ek_q = ek_q;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rf_bus.Sys_rdy         = t.rdy;
      rf_bus.RoBRF_pre_judge = t.pj;
      rf_bus.RoBRF_en        = t.c_en;
      rf_bus.RoBRF_rd        = t.c_rd;
      rf_bus.RoBRF_RoB_index = t.c_rob;
      rf_bus.RoBRF_value     = t.c_val;
      rf_bus.DPRF_en         = t.d_en;
      rf_bus.DPRF_rd         = t.d_rd;
      rf_bus.DPRF_RoB_index  = t.d_rob;
      rf_bus.DPRF_rs1        = t.rs1;
      rf_bus.DPRF_rs2        = t.rs2;
   endtask

   task automatic check_reads(input string tag, input vec_t t);
      check({tag, " Vj"}, rf_bus.RFDP_Vj, t.ej_v);
      check({tag, " Qj"}, {23'd0, rf_bus.RFDP_Qj}, {23'd0, t.ej_q});
      check({tag, " Vk"}, rf_bus.RFDP_Vk, t.ek_v);
      check({tag, " Qk"}, {23'd0, rf_bus.RFDP_Qk}, {23'd0, t.ek_q});
   endtask

   initial begin
      vec_t idle;
      vec_t t;
      n_cmp = 0;
      n_bad = 0;
      idle  = mk(1,1, 0,NR,0,0, 0,NR,0, NR,NR, 0,ND,0,ND);
      drive(idle);
      rst_n = 1'b0;

      //        rdy pj  commit(en,rd,rob,val)  rename(en,rd,rob) rs1 rs2  Vj Qj Vk Qk (pre-edge)
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd5,NR, 0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd3,7, 6'd3,NR, 0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd3,NR, 0,9'd7,0,ND));
      vecs.push_back(mk(1,1, 1,6'd3,7,32'hDEAD, 0,NR,0,   6'd3,6'd3, 32'hDEAD,ND,32'hDEAD,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd3,6'd3, 32'hDEAD,ND,32'hDEAD,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd4,1, 6'd4,NR, 0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd4,2, 6'd4,NR, 0,9'd1,0,ND));
      vecs.push_back(mk(1,1, 1,6'd4,1,32'h11,   0,NR,0,   6'd4,NR, 0,9'd2,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd4,NR, 32'h11,9'd2,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd6,9, NR,NR,   0,ND,0,ND));
      vecs.push_back(mk(1,1, 1,6'd6,9,32'h66,   1,6'd6,12, 6'd6,NR, 32'h66,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd6,NR, 32'h66,9'd12,0,ND));
      vecs.push_back(mk(0,1, 0,NR,0,0,          1,6'd7,5, 6'd7,NR, 0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd7,6'd4, 0,ND,32'h11,9'd2));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd1,20, NR,NR,  0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd2,21, NR,NR,  0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          1,6'd8,22, 6'd1,6'd2, 0,9'd20,0,9'd21));
      vecs.push_back(mk(1,0, 1,6'd1,30,32'h40,  1,6'd5,3, NR,NR,   0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd1,6'd8, 32'h40,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd5,6'd6, 0,ND,32'h66,ND));
      vecs.push_back(mk(1,1, 1,6'd0,0,32'h55,   1,6'd0,4, 6'd0,NR, 0,ND,0,ND));
      vecs.push_back(mk(1,1, 0,NR,0,0,          0,NR,0,   6'd0,6'd0, 0,ND,0,ND));

      repeat (2) @(negedge clk);
      check_reads("reset", mk(1,1,0,NR,0,0,0,NR,0,NR,NR,0,ND,0,ND));
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check_reads($sformatf("vec%0d", i), vecs[i]);
      end

      // Asynchronous reset mid-stream clears state without waiting for a clock edge
      @(negedge clk);
      t = mk(1,1, 0,NR,0,0, 1,6'd10,50, 6'd1,6'd10, 0,ND,0,ND);
      drive(t);
      @(negedge clk);
      drive(idle);
      rf_bus.DPRF_rs1 = 6'd1;
      rf_bus.DPRF_rs2 = 6'd10;
      #1;
      check_reads("pre_rst", mk(1,1,0,NR,0,0,0,NR,0,NR,NR,32'h40,ND,0,9'd50));
      #1;
      rst_n = 1'b0;
      #1;
      check_reads("async_rst", mk(1,1,0,NR,0,0,0,NR,0,NR,NR,0,ND,0,ND));
      @(negedge clk);
      rst_n = 1'b1;
      rf_bus.DPRF_rs1 = 6'd3;
      rf_bus.DPRF_rs2 = 6'd6;
      #1;
      check_reads("post_rst", mk(1,1,0,NR,0,0,0,NR,0,NR,NR,0,ND,0,ND));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the reorder buffer's commit port and beside the dispatcher.
- Dispatcher reads source operands (value or RoB dependency tag) and records the destination rename on issue. Reorder buffer commits results into it.
- A misprediction flush clears all rename tags, leaving committed values intact.

Parameters:
- REG_WIDTH, 5, architectural register index width
- EX_REG_WIDTH, 6, register index plus "no register" bit
- NON_REG, 6'b100000, encoding for "no register operand"
- RoB_WIDTH, 8, reorder buffer index width
- EX_RoB_WIDTH, 9, tag width (RoB index plus "no dependency" bit)
- NON_DEP, 9'b100000000, tag meaning "value is architectural / no dependency"
- REG_NUM, 32, number of registers

Ports:
- Sys_clk  in  1  clock, all state on rising edge
- Sys_rst_n  in  1  asynchronous active-low reset
- Sys_rdy  in  1  global enable; no state change when low (reset still acts)
- RoBRF_pre_judge  in  1  0 = mispredict flush this cycle
- RoBRF_en  in  1  commit valid
- RoBRF_RoB_index  in  RoB_WIDTH  RoB index of the committing instruction
- RoBRF_rd  in  EX_REG_WIDTH  committing destination register
- RoBRF_value  in  32  committed value
- DPRF_rs1  in  EX_REG_WIDTH  source 1 index (NON_REG = unused)
- DPRF_rs2  in  EX_REG_WIDTH  source 2 index (NON_REG = unused)
- DPRF_en  in  1  issue: rename DPRF_rd to DPRF_RoB_index
- DPRF_rd  in  EX_REG_WIDTH  destination of the issuing instruction
- DPRF_RoB_index  in  RoB_WIDTH  RoB slot allocated to the issuing instruction
- RFDP_Vj  out  32  source 1 value (valid when RFDP_Qj == NON_DEP)
- RFDP_Vk  out  32  source 2 value
- RFDP_Qj  out  EX_RoB_WIDTH  source 1 dependency tag or NON_DEP
- RFDP_Qk  out  EX_RoB_WIDTH  source 2 dependency tag or NON_DEP

Behaviour:
- State: value[0..31] (32 bits each), tag[0..31] (EX_RoB_WIDTH bits each). No FSM.
- Reset (async, Sys_rst_n low): all values become 0 and all tags become NON_DEP. Outputs are combinational, so after reset they read 0 / NON_DEP.
- Read path is combinational and has zero latency. rs == NON_REG or rs == 0 -> V = 0, Q = NON_DEP.
- Otherwise, with no bypass: V = value[rs], Q = tag[rs].
- Commit bypass: if RoBRF_en, RoBRF_rd == rs, and tag[rs] == {0, RoBRF_RoB_index}, then V = RoBRF_value and Q = NON_DEP in the same cycle.
- Reads never see the same-cycle DPRF rename. For "add x1,x1,x2", Qj is the old tag of x1.
- Commit (posedge, Sys_rdy, RoBRF_en, rd not in {0, NON_REG}): value[rd] <= RoBRF_value always.
  - tag[rd] <= NON_DEP only if tag[rd] == RoB index and no same-cycle rename of rd.
  - A stale commit (tag mismatch) updates the value only; the tag is kept.
- Rename (posedge, Sys_rdy, DPRF_en, pre_judge = 1, rd not in {0, NON_REG}): tag[rd] <= {0, DPRF_RoB_index}.
- Simultaneous commit and rename on the same rd: the rename wins the tag; the commit still writes the value.
- Flush (RoBRF_pre_judge == 0 with Sys_rdy): all tags <= NON_DEP. DPRF_en is ignored.
  - A commit arriving in the flush cycle still writes its value. It is the branch's own commit and must not be lost.
  - Read outputs during the flush cycle are don't-care for the dispatcher.
- x0 is never written and its tag is never set.
- Sys_rdy low: state holds and reads stay live.

Optional Feature:
- REGFILE_TRACE_EN defined: on every value write, simulation-only $display of "rf x%0d <= %h (rob %0d)". It also asserts that a rename never targets an index with bit EX_RoB_WIDTH-1 set.
- Not defined: no display or assertion code; RTL is otherwise identical.

Decomposition:
- Shared package holds NON_REG, NON_DEP, and the width constants (REG_WIDTH, EX_REG_WIDTH, RoB_WIDTH, EX_RoB_WIDTH), shared with the dispatcher and reorder buffer.
- One natural sub-module: rf_read_port (combinational rs -> V/Q with commit bypass), instantiated twice for rs1 and rs2.

Test Plan:
- Reset then read rs1=5, rs2=NON_REG -> Vj=0, Qj=NON_DEP, Vk=0, Qk=NON_DEP.
- Issue rd=3, rob=7. Next cycle read rs1=3 -> Qj=7. Commit rd=3, rob=7, value=0xDEAD -> same-cycle Vj=0xDEAD, Qj=NON_DEP; afterwards tag[3]=NON_DEP.
- Issue rd=4, rob=1, then rd=4, rob=2. Commit rob=1, value=0x11 -> value[4]=0x11, tag stays 2. Read rs1=4 -> Qj=2.
- Same cycle: commit rd=6, rob=9 (tag[6]=9) and rename rd=6, rob=12 -> value[6] updated, tag[6]=12.
- Tags set on x1, x2, x8, then pre_judge=0 with commit rd=1, value=0x40 and DPRF_en=1 rd=5 -> all tags NON_DEP, value[1]=0x40, tag[5] untouched.
- Rename and commit targeting rd=0 -> read rs1=0 gives 0 / NON_DEP. Assert Sys_rst_n mid-stream -> all tags NON_DEP and values 0 immediately.
